rx_rs232: RTL
=============

// Module: rx_rs232
// PURPOSE
//  Receiving end of the tx_rs232 serial link: async serial in, 8N1 frame, LSB first, idle high.
//  Synchronises the serial line and validates the start bit at mid-bit.
//  Samples 8 data bits and checks the stop bit; presents the byte with a one-cycle completion pulse.
//  Sits opposite tx_rs232 and must share its CLKS_PER_BIT setting.
// PARAMETERS
//  CLKS_PER_BIT  16  clk_s cycles per serial bit (even, >=4); must equal transmitter's bit period
// PORTS
//  clk_s    in   1  system clock; all logic on rising edge
//  rstn_s   in   1  asynchronous active-low reset
//  iDATA    in   1  serial line from transmitter; asynchronous, idle high
//  oDATA    out  8  last correctly received byte; LSB = first data bit on the line
//  oFINISH  out  1  one-cycle pulse: good frame received, oDATA updated in the same cycle
//  oERROR   out  1  one-cycle pulse: framing error (stop bit sampled low)
//  oBUSY    out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//  Reset (async, rstn_s=0): state=IDLE, oDATA=8'h00, oFINISH=0, oERROR=0, oBUSY=0.
//   Sync flops reset to 1 (idle). Reset mid-frame aborts the frame with no pulses.
//  Input: 2-flop synchroniser on iDATA -> rx_s. Only rx_s is used internally.
//  Counters: bit-timer cnt, width ceil(log2(CLKS_PER_BIT)); bit index idx, 3 bits; shift reg sh[7:0].
//  States:
//   IDLE: oBUSY=0. rx_s==0 -> START with cnt=0.
//   START: cnt++ each cycle. At cnt==CLKS_PER_BIT/2-1 (mid start bit):
//    rx_s==1 -> glitch: IDLE, no outputs.
//    rx_s==0 -> DATA with cnt=0, idx=0.
//   DATA: cnt++. At cnt==CLKS_PER_BIT-1 (mid data bit): sh={rx_s,sh[7:1]}, cnt=0.
//    idx==7 -> STOP; else idx++.
//   STOP: cnt++. At cnt==CLKS_PER_BIT-1 (mid stop bit):
//    rx_s==1 -> oDATA<=sh, oFINISH=1 for one cycle, go IDLE.
//    rx_s==0 -> oERROR=1 for one cycle, oDATA unchanged, go WAIT_IDLE.
//   WAIT_IDLE: stay until rx_s==1, then IDLE. This blocks false start detection inside a break/low line.
//  Back-to-back frames: IDLE is re-entered at mid stop bit. The next start edge, half a bit later, is caught.
//  Latency: oFINISH/oERROR asserts 9.5*CLKS_PER_BIT + 2..4 cycles after the iDATA falling edge of the start bit.
//  oFINISH and oERROR are never high together. oDATA changes only in the oFINISH cycle.
//  oBUSY=1 in START, DATA, STOP and WAIT_IDLE.
//  No parity, no oversampled majority vote, no FIFO: the consumer must take oDATA before the next oFINISH.
// TESTING
//  Clock period 2 ns, CLKS_PER_BIT=16; stimulus by tx_rs232 or a bench bit-driver. Check all outputs at/after reset.
//  1 Reset -> oDATA=00, oFINISH=0, oERROR=0, oBUSY=0. Then idle line for 100 cycles -> no pulses.
//  2 Send 8'h11 -> single oFINISH pulse with oDATA=8'h11 in the latency window.
//    Then 8'hA5, 8'h00, 8'hFF with no idle gap -> four pulses, values in order.
//  3 Frame 8'h3C with stop bit driven 0, then line high -> oERROR pulse, no oFINISH, oDATA keeps its prior value.
//    Next frame 8'h5A -> received OK.
//  4 Low glitch of 4 cycles on the idle line -> no pulses, oBUSY back to 0 within CLKS_PER_BIT/2+3 cycles.
//    Then 8'h81 -> received OK.
//  5 rstn_s pulsed low during bit 4 of 8'hC3 -> outputs reset immediately, no pulse for the aborted frame.
//    Next full frame 8'h7E -> received OK.
//  6 Line held low for 3 frame times, then released -> one oERROR, no further pulses until a fresh valid frame.

Source files
------------

// File: rtl/rx_rs232.sv
// 8N1 serial receiver: synchronises the line, validates the start bit at mid-bit,
// samples eight data bits LSB first and flags good frames or framing errors.
module rx_rs232 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_s,
  input  logic       rstn_s,
  input  logic       iDATA,
  output logic [7:0] oDATA,
  output logic       oFINISH,
  output logic       oERROR,
  output logic       oBUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } stateT;

  stateT       state, stateNext;
  logic        syncMeta, rxSync;
  logic [CW-1:0] cnt, cntNext;
  logic [2:0]  idx, idxNext;
  logic [7:0]  sh, shNext;
  logic [7:0]  dataNext;
  logic        finishNext, errorNext;

  // Sync flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      syncMeta <= 1'b1;
      rxSync   <= 1'b1;
    end else begin
      syncMeta <= iDATA;
      rxSync   <= syncMeta;
    end
  end

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      oDATA   <= '0;
      oFINISH <= 1'b0;
      oERROR  <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      idx     <= idxNext;
      sh      <= shNext;
      oDATA   <= dataNext;
      oFINISH <= finishNext;
      oERROR  <= errorNext;
    end
  end

  // Start is sampled half a bit in; every later sample lands one full bit after the previous.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    idxNext    = idx;
    shNext     = sh;
    dataNext   = oDATA;
    finishNext = 1'b0;
    errorNext  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxSync) begin
          stateNext = START;
          cntNext   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          if (rxSync) begin
            stateNext = IDLE;
          end else begin
            stateNext = DATA;
            cntNext   = '0;
            idxNext   = '0;
          end
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          shNext  = {rxSync, sh[7:1]};
          cntNext = '0;
          if (idx == 3'd7) begin
            stateNext = STOP;
          end else begin
            idxNext = idx + 3'd1;
          end
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cntNext = '0;
          if (rxSync) begin
            dataNext   = sh;
            finishNext = 1'b1;
            stateNext  = IDLE;
          end else begin
            errorNext = 1'b1;
            stateNext = WAIT_IDLE;
          end
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A held-low (break) line must go high before a new start can be trusted.
        if (rxSync) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign oBUSY = (state != IDLE);

endmodule
